// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-SRAM port controller.
// Response-owner encoding, default bus widths and the fetch NOP word.
package imem_pkg;

  localparam int unsigned IMEM_AW      = 10;
  localparam int unsigned IMEM_DW      = 32;
  localparam int unsigned STARVE_CNT_W = 4;

  // Instruction substituted by fetch consumers when no valid word is available
  localparam logic [31:0] IMEM_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    R_NONE  = 2'd0,
    R_FETCH = 2'd1,
    R_LDR   = 2'd2
  } resp_owner_t;

endpackage

// File: rtl/imem_starve_cnt.sv
// Loader starvation guard: counts consecutive fetch wins while the loader waits
// and flags when the loader must be given the next slot.
module imem_starve_cnt
  import imem_pkg::*;
#(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ldr_req_i,
  input  logic fetch_gnt_i,
  input  logic ldr_gnt_i,
  output logic starve_o
);

  logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;
  logic                    starve_q, starve_d;

  // Flag is registered from the next count so it equals (cnt_q == LIMIT)
  always_comb begin
    cnt_d = cnt_q;
    if (!ldr_req_i || ldr_gnt_i) begin
      cnt_d = '0;
    end else if (fetch_gnt_i) begin
      cnt_d = cnt_q + STARVE_CNT_W'(1);
    end
    starve_d = (cnt_d == STARVE_CNT_W'(LIMIT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      starve_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
    end
  end

  assign starve_o = starve_q;

endmodule

// File: rtl/imem_port_ctrl.sv
// Single-port instruction SRAM arbiter: fetch refill vs. loader/debug port.
// Optional loader starvation guard built when IMEM_ARB_STARVE_GUARD_EN is defined.
module imem_port_ctrl
  import imem_pkg::*;
#(
  parameter int unsigned AW           = IMEM_AW,
  parameter int unsigned DW           = IMEM_DW,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          fetch_req_i,
  input  logic [AW-1:0] fetch_addr_i,
  input  logic          flush_i,
  output logic          fetch_gnt_o,
  output logic          fetch_rvalid_o,
  output logic [DW-1:0] fetch_rdata_o,
  input  logic          ldr_req_i,
  input  logic          ldr_we_i,
  input  logic [AW-1:0] ldr_addr_i,
  input  logic [DW-1:0] ldr_wdata_i,
  output logic          ldr_gnt_o,
  output logic          ldr_rvalid_o,
  output logic [DW-1:0] ldr_rdata_o,
  output logic          sram_ceb_o,
  output logic          sram_web_o,
  output logic [AW-1:0] sram_a_o,
  output logic [DW-1:0] sram_d_o,
  input  logic [DW-1:0] sram_q_i
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > (2 ** STARVE_CNT_W) - 1) begin : g_bad_limit
    $error("imem_port_ctrl: STARVE_LIMIT out of range");
  end

  resp_owner_t   resp_q, resp_d;
  logic [AW-1:0] a_q, a_d;
  logic [DW-1:0] d_q, d_d;
  logic          starve_fire;

`ifdef IMEM_ARB_STARVE_GUARD_EN
  logic starve;

  imem_starve_cnt #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_cnt (
    .clk         (clk),
    .rst_n       (resetn),
    .ldr_req_i   (ldr_req_i),
    .fetch_gnt_i (fetch_gnt_o),
    .ldr_gnt_i   (ldr_gnt_o),
    .starve_o    (starve)
  );

  assign starve_fire = starve & ldr_req_i;
`else
  assign starve_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      resp_q <= R_NONE;
      a_q    <= '0;
      d_q    <= '0;
    end else begin
      resp_q <= resp_d;
      a_q    <= a_d;
      d_q    <= d_d;
    end
  end

  // Same-cycle arbitration; address/data hold their last value when idle
  always_comb begin
    fetch_gnt_o = 1'b0;
    ldr_gnt_o   = 1'b0;
    resp_d      = R_NONE;
    sram_ceb_o  = 1'b1;
    sram_web_o  = 1'b1;
    a_d         = a_q;
    d_d         = d_q;
    if (resetn) begin
      if (fetch_req_i && !flush_i && !starve_fire) begin
        fetch_gnt_o = 1'b1;
      end else if (ldr_req_i) begin
        ldr_gnt_o = 1'b1;
      end
    end
    if (fetch_gnt_o) begin
      sram_ceb_o = 1'b0;
      a_d        = fetch_addr_i;
      d_d        = ldr_wdata_i;
      resp_d     = R_FETCH;
    end else if (ldr_gnt_o) begin
      sram_ceb_o = 1'b0;
      sram_web_o = !ldr_we_i;
      a_d        = ldr_addr_i;
      d_d        = ldr_wdata_i;
      resp_d     = ldr_we_i ? R_NONE : R_LDR;
    end
    sram_a_o = a_d;
    sram_d_o = d_d;
  end

  // Flush in the response cycle drops stale fetch data; loader data always returns
  always_comb begin
    fetch_rvalid_o = (resp_q == R_FETCH) && !flush_i;
    ldr_rvalid_o   = (resp_q == R_LDR);
    fetch_rdata_o  = fetch_rvalid_o ? sram_q_i : '0;
    ldr_rdata_o    = ldr_rvalid_o ? sram_q_i : '0;
  end

endmodule

// File: tb/tb_imem_port_ctrl.sv
// Self-checking bench for imem_port_ctrl: directed scenarios plus randomized traffic
// against a transaction-level model with a shadow SRAM image.
module tb_imem_port_ctrl;
  import imem_pkg::*;

  localparam int unsigned AW    = 10;
  localparam int unsigned DW    = 32;
  localparam int unsigned LIMIT = 4;
  localparam int unsigned DEPTH = 1 << AW;
`ifdef IMEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk;
  logic          resetn;
  logic          fetch_req_i;
  logic [AW-1:0] fetch_addr_i;
  logic          flush_i;
  logic          fetch_gnt_o;
  logic          fetch_rvalid_o;
  logic [DW-1:0] fetch_rdata_o;
  logic          ldr_req_i;
  logic          ldr_we_i;
  logic [AW-1:0] ldr_addr_i;
  logic [DW-1:0] ldr_wdata_i;
  logic          ldr_gnt_o;
  logic          ldr_rvalid_o;
  logic [DW-1:0] ldr_rdata_o;
  logic          sram_ceb_o;
  logic          sram_web_o;
  logic [AW-1:0] sram_a_o;
  logic [DW-1:0] sram_d_o;
  logic [DW-1:0] sram_q_i;

  int checks;
  int errors;

  imem_port_ctrl #(
    .AW           (AW),
    .DW           (DW),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .fetch_req_i    (fetch_req_i),
    .fetch_addr_i   (fetch_addr_i),
    .flush_i        (flush_i),
    .fetch_gnt_o    (fetch_gnt_o),
    .fetch_rvalid_o (fetch_rvalid_o),
    .fetch_rdata_o  (fetch_rdata_o),
    .ldr_req_i      (ldr_req_i),
    .ldr_we_i       (ldr_we_i),
    .ldr_addr_i     (ldr_addr_i),
    .ldr_wdata_i    (ldr_wdata_i),
    .ldr_gnt_o      (ldr_gnt_o),
    .ldr_rvalid_o   (ldr_rvalid_o),
    .ldr_rdata_o    (ldr_rdata_o),
    .sram_ceb_o     (sram_ceb_o),
    .sram_web_o     (sram_web_o),
    .sram_a_o       (sram_a_o),
    .sram_d_o       (sram_d_o),
    .sram_q_i       (sram_q_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM macro
  logic [DW-1:0] sram_mem [DEPTH];
  always @(posedge clk) begin
    if (!sram_ceb_o) begin
      if (!sram_web_o) sram_mem[sram_a_o] <= sram_d_o;
      else             sram_q_i <= sram_mem[sram_a_o];
    end
  end

  // Reference model: shadow memory, who owns the in-flight read, its data, and wait count
  logic [DW-1:0] ref_mem [DEPTH];
  int            m_owner;   // 0 none, 1 fetch, 2 loader
  logic [DW-1:0] m_rdata;
  logic [AW-1:0] m_last_a;
  logic [DW-1:0] m_last_d;
  int            m_sc;

  bit            e_fgnt, e_lgnt, e_ceb, e_web, e_frv, e_lrv;
  logic [AW-1:0] e_a;
  logic [DW-1:0] e_d, e_frd, e_lrd;

  task automatic model_reset();
    m_owner  = 0;
    m_rdata  = '0;
    m_last_a = '0;
    m_last_d = '0;
    m_sc     = 0;
  endtask

  task automatic apply(input bit fr, input logic [AW-1:0] fa, input bit fl, input bit lr,
                       input bit lw, input logic [AW-1:0] la, input logic [DW-1:0] ld);
    bit starve;
    fetch_req_i  = fr;
    fetch_addr_i = fa;
    flush_i      = fl;
    ldr_req_i    = lr;
    ldr_we_i     = lw;
    ldr_addr_i   = la;
    ldr_wdata_i  = ld;
    starve = GUARD && (m_sc == int'(LIMIT)) && lr;
    e_fgnt = resetn && fr && !fl && !starve;
    e_lgnt = resetn && lr && !e_fgnt;
    e_ceb  = !(e_fgnt || e_lgnt);
    e_web  = !(e_lgnt && lw);
    e_a    = e_fgnt ? fa : (e_lgnt ? la : m_last_a);
    e_d    = (e_fgnt || e_lgnt) ? ld : m_last_d;
    e_frv  = (m_owner == 1) && !fl;
    e_lrv  = (m_owner == 2);
    e_frd  = e_frv ? m_rdata : '0;
    e_lrd  = e_lrv ? m_rdata : '0;
  endtask

  task automatic apply_idle();
    apply(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic tick();
    @(posedge clk);
    if (e_fgnt) begin
      m_owner = 1;
      m_rdata = ref_mem[e_a];
    end else if (e_lgnt && !ldr_we_i) begin
      m_owner = 2;
      m_rdata = ref_mem[e_a];
    end else begin
      m_owner = 0;
    end
    if (e_lgnt && ldr_we_i) ref_mem[e_a] = ldr_wdata_i;
    if (!e_ceb) begin
      m_last_a = e_a;
      m_last_d = e_d;
    end
    if (!ldr_req_i || e_lgnt) m_sc = 0;
    else if (e_fgnt)          m_sc = m_sc + 1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    apply(1'b1, 10'h005, 1'b0, 1'b1, 1'b1, 10'h007, 32'hA5A5_A5A5);
    #1;
    checks++; if (fetch_gnt_o !== 1'b0) begin errors++; $display("FAIL reset_fgnt got=%b exp=0", fetch_gnt_o); end
    checks++; if (ldr_gnt_o !== 1'b0) begin errors++; $display("FAIL reset_lgnt got=%b exp=0", ldr_gnt_o); end
    checks++; if (sram_ceb_o !== 1'b1) begin errors++; $display("FAIL reset_ceb got=%b exp=1", sram_ceb_o); end
    checks++; if (sram_web_o !== 1'b1) begin errors++; $display("FAIL reset_web got=%b exp=1", sram_web_o); end
    checks++; if (sram_a_o !== '0) begin errors++; $display("FAIL reset_a got=%h exp=0", sram_a_o); end
    checks++; if (sram_d_o !== '0) begin errors++; $display("FAIL reset_d got=%h exp=0", sram_d_o); end
    checks++; if (fetch_rvalid_o !== 1'b0 || ldr_rvalid_o !== 1'b0) begin
      errors++; $display("FAIL reset_rvalid got=%b%b exp=00", fetch_rvalid_o, ldr_rvalid_o); end
    checks++; if (fetch_rdata_o !== '0 || ldr_rdata_o !== '0) begin
      errors++; $display("FAIL reset_rdata got=%h/%h exp=0", fetch_rdata_o, ldr_rdata_o); end
    apply_idle();
    resetn = 1'b1;
    #1;
  endtask

  task automatic test_fetch_only();
    apply(1'b1, 10'h010, 1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    checks++; if (fetch_gnt_o !== 1'b1) begin errors++; $display("FAIL fetch_gnt got=%b exp=1", fetch_gnt_o); end
    checks++; if (sram_a_o !== 10'h010 || sram_ceb_o !== 1'b0) begin
      errors++; $display("FAIL fetch_sram a=%h ceb=%b exp a=010 ceb=0", sram_a_o, sram_ceb_o); end
    tick();
    apply_idle();
    #1;
    checks++; if (fetch_rvalid_o !== 1'b1) begin errors++; $display("FAIL fetch_rvalid got=%b exp=1", fetch_rvalid_o); end
    checks++; if (fetch_rdata_o !== sram_mem[10'h010]) begin
      errors++; $display("FAIL fetch_rdata got=%h exp=%h", fetch_rdata_o, sram_mem[10'h010]); end
    tick();
  endtask

  task automatic test_loader_wr_rd();
    apply(1'b0, '0, 1'b0, 1'b1, 1'b1, 10'h3FF, 32'hDEAD_BEEF);
    #1;
    checks++; if (ldr_gnt_o !== 1'b1 || sram_web_o !== 1'b0 || sram_ceb_o !== 1'b0) begin
      errors++; $display("FAIL ldr_wr_ctl gnt=%b web=%b ceb=%b exp 1/0/0", ldr_gnt_o, sram_web_o, sram_ceb_o); end
    checks++; if (sram_a_o !== 10'h3FF || sram_d_o !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL ldr_wr_bus a=%h d=%h exp 3ff/deadbeef", sram_a_o, sram_d_o); end
    tick();
    apply(1'b0, '0, 1'b0, 1'b1, 1'b0, 10'h3FF, '0);
    #1;
    checks++; if (ldr_rvalid_o !== 1'b0) begin errors++; $display("FAIL ldr_wr_noresp got=%b exp=0", ldr_rvalid_o); end
    checks++; if (ldr_gnt_o !== 1'b1 || sram_web_o !== 1'b1) begin
      errors++; $display("FAIL ldr_rd_ctl gnt=%b web=%b exp 1/1", ldr_gnt_o, sram_web_o); end
    tick();
    apply_idle();
    #1;
    checks++; if (ldr_rvalid_o !== 1'b1 || ldr_rdata_o !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL ldr_rd_data rv=%b d=%h exp 1/deadbeef", ldr_rvalid_o, ldr_rdata_o); end
    tick();
  endtask

  task automatic test_contention();
    bit exp_l;
    for (int i = 0; i < 10; i++) begin
      apply(1'b1, AW'(i + 'h40), 1'b0, 1'b1, 1'b0, AW'(i + 'h80), '0);
      #1;
`ifdef IMEM_ARB_STARVE_GUARD_EN
      exp_l = ((i % (LIMIT + 1)) == LIMIT);
`else
      exp_l = 1'b0;
`endif
      checks++; if (fetch_gnt_o !== !exp_l || ldr_gnt_o !== exp_l) begin
        errors++; $display("FAIL contention cyc=%0d fgnt=%b lgnt=%b exp %b/%b", i, fetch_gnt_o, ldr_gnt_o, !exp_l, exp_l); end
      tick();
    end
    apply_idle();
    tick();
  endtask

  task automatic test_flush_kill();
    apply(1'b1, 10'h020, 1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    checks++; if (fetch_gnt_o !== 1'b1) begin errors++; $display("FAIL flush_pre_gnt got=%b exp=1", fetch_gnt_o); end
    tick();
    apply(1'b1, 10'h021, 1'b1, 1'b1, 1'b0, 10'h022, '0);
    #1;
    checks++; if (fetch_rvalid_o !== 1'b0 || fetch_rdata_o !== '0) begin
      errors++; $display("FAIL flush_kill rv=%b d=%h exp 0/0", fetch_rvalid_o, fetch_rdata_o); end
    checks++; if (fetch_gnt_o !== 1'b0 || ldr_gnt_o !== 1'b1 || sram_a_o !== 10'h022) begin
      errors++; $display("FAIL flush_arb fgnt=%b lgnt=%b a=%h exp 0/1/022", fetch_gnt_o, ldr_gnt_o, sram_a_o); end
    tick();
    apply_idle();
    #1;
    checks++; if (ldr_rvalid_o !== 1'b1 || ldr_rdata_o !== e_lrd || fetch_rvalid_o !== 1'b0) begin
      errors++; $display("FAIL flush_ldr_resp lrv=%b d=%h frv=%b exp 1/%h/0", ldr_rvalid_o, ldr_rdata_o, fetch_rvalid_o, e_lrd); end
    tick();
  endtask

  task automatic test_reset_midread();
    apply(1'b1, 10'h030, 1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    checks++; if (fetch_gnt_o !== 1'b1) begin errors++; $display("FAIL midrst_gnt got=%b exp=1", fetch_gnt_o); end
    resetn = 1'b0;
    #1;
    checks++; if (fetch_gnt_o !== 1'b0 || sram_ceb_o !== 1'b1 || sram_a_o !== '0) begin
      errors++; $display("FAIL midrst_async gnt=%b ceb=%b a=%h exp 0/1/0", fetch_gnt_o, sram_ceb_o, sram_a_o); end
    model_reset();
    apply_idle();
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    apply_idle();
    #1;
    checks++; if (fetch_rvalid_o !== 1'b0 || ldr_rvalid_o !== 1'b0) begin
      errors++; $display("FAIL midrst_lost frv=%b lrv=%b exp 0/0", fetch_rvalid_o, ldr_rvalid_o); end
    tick();
    apply(1'b1, 10'h031, 1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    checks++; if (fetch_gnt_o !== 1'b1) begin errors++; $display("FAIL midrst_regrant got=%b exp=1", fetch_gnt_o); end
    tick();
    apply_idle();
    #1;
    checks++; if (fetch_rvalid_o !== 1'b1 || fetch_rdata_o !== e_frd) begin
      errors++; $display("FAIL midrst_resp rv=%b d=%h exp 1/%h", fetch_rvalid_o, fetch_rdata_o, e_frd); end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      apply($urandom_range(0, 3) != 0, AW'($urandom_range(0, 15)), $urandom_range(0, 7) == 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, AW'($urandom_range(0, 15)), $urandom);
      #1;
      checks++; if (fetch_gnt_o !== e_fgnt) begin errors++; $display("FAIL rand_fgnt cyc=%0d got=%b exp=%b", c, fetch_gnt_o, e_fgnt); end
      checks++; if (ldr_gnt_o !== e_lgnt) begin errors++; $display("FAIL rand_lgnt cyc=%0d got=%b exp=%b", c, ldr_gnt_o, e_lgnt); end
      checks++; if (sram_ceb_o !== e_ceb || sram_web_o !== e_web) begin
        errors++; $display("FAIL rand_ctl cyc=%0d ceb=%b web=%b exp %b/%b", c, sram_ceb_o, sram_web_o, e_ceb, e_web); end
      checks++; if (sram_a_o !== e_a || sram_d_o !== e_d) begin
        errors++; $display("FAIL rand_bus cyc=%0d a=%h d=%h exp %h/%h", c, sram_a_o, sram_d_o, e_a, e_d); end
      checks++; if (fetch_rvalid_o !== e_frv || fetch_rdata_o !== e_frd) begin
        errors++; $display("FAIL rand_fresp cyc=%0d rv=%b d=%h exp %b/%h", c, fetch_rvalid_o, fetch_rdata_o, e_frv, e_frd); end
      checks++; if (ldr_rvalid_o !== e_lrv || ldr_rdata_o !== e_lrd) begin
        errors++; $display("FAIL rand_lresp cyc=%0d rv=%b d=%h exp %b/%h", c, ldr_rvalid_o, ldr_rdata_o, e_lrv, e_lrd); end
      tick();
    end
    apply_idle();
    tick();
  endtask

  initial begin
    logic [DW-1:0] v;
    checks = 0;
    errors = 0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      v = $urandom;
      sram_mem[i] = v;
      ref_mem[i]  = v;
    end
    sram_q_i = '0;
    resetn   = 1'b0;
    model_reset();
    apply_idle();
    test_reset();
    test_fetch_only();
    test_loader_wr_rd();
    test_contention();
    test_flush_kill();
    test_reset_midread();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
